pattern_encoder: RTL
====================

# pattern_encoder

Streaming encoder for sparse-matrix index patterns. It accepts row-major (row, col) index pairs, delta-encodes them into 16-bit codes, and packs four codes per 64-bit word. Packed words go to memory through a request/stall write port at consecutive word addresses. It produces the code stream that pattern_decoder consumes and is the write-side counterpart of that block.

## Interface
- INDEX_WIDTH, 32, row/col width
- ADDR_WIDTH, 48, word address width
- DATA_WIDTH, 64, memory word width (fixed at 4 codes × 16 bits)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begin new stream
- start_addr  in  ADDR_WIDTH  first word address, sampled with start
- index_push  in  1  index valid; accepted when index_push && !index_stall
- index_stall  out  1  encoder cannot accept an index this cycle
- row  in  INDEX_WIDTH  row index
- col  in  INDEX_WIDTH  column index
- finish  in  1  one-cycle pulse; no more indexes, flush
- wr_req  out  1  write word valid
- wr_stall  in  1  memory not accepting; transfer = wr_req && !wr_stall
- wr_addr  out  ADDR_WIDTH  word address
- wr_data  out  DATA_WIDTH  packed codes, code 0 in [15:0]
- done  out  1  one-cycle pulse after last word accepted
- word_count  out  ADDR_WIDTH  words written in current stream
- err  out  1  sticky ordering/range error

## Operation
- Code format: [15:14] type, [13:0] payload. 00 = column delta (payload ≥1). 01 = row advance by payload (≥1). 10 = high extension: payload is delta[27:14] of the next 00/01 code. 0x0000 = end/pad.
- State: row_prev, col_prev. Start sets row_prev = 0, col_prev = −1.
- Per index: if row > row_prev, emit row advance d = row − row_prev, then set col_prev = −1 and row_prev = row. Then emit column delta col − col_prev; set col_prev = col.
- Any delta ≥ 2^14 is preceded by a type-10 code. A delta ≥ 2^28 is a range error.
- FSM IDLE→RUN on start; RUN→FLUSH on finish; FLUSH emits 0x0000, then pads 0x0000 to a word boundary (none if already aligned after the end code); DRAIN until the output register empties; DONE for one cycle (done=1); → IDLE.
- Packer: 4-code shift register plus one 64-bit output register. A full word moves to the output register when it is empty or being accepted the same cycle. wr_addr = start_addr + word_count. word_count increments on each accepted write.
- index_stall is high when: not in RUN; the current index still has pending codes; or the packer is blocked (4 codes held and output register full and not draining).
- start while not IDLE is ignored. finish in IDLE is ignored. index_push outside RUN is ignored.

## Timing
- Reset values: index_stall=1, wr_req=0, wr_addr=0, wr_data=0, done=0, word_count=0, err=0, FSM=IDLE.
- start at cycle N → RUN at N+1; index_stall low at N+1.
- One code emitted per cycle. The first code of an index accepted at N enters the packer at N+1. Throughput is 1 index/cycle when each index yields one code.
- The 4th code entering at cycle M → wr_req high at M+1 with that word.
- wr_req, wr_addr, wr_data are held stable while wr_stall=1.
- done is asserted the cycle after the final accepted write.
- finish and index_push in the same cycle: the index is encoded first, then the flush.
- An async reset mid-stream discards all partial codes and words; no write is issued.

## Configuration
- PATTERN_ENCODER_CHECK_EN defined: row < row_prev, or same row with col ≤ col_prev, or delta ≥ 2^28, sets err sticky until next start; the offending index is dropped (no codes, state unchanged).
- Undefined: err tied 0; no checks. Deltas are computed modulo 2^28 and emitted blindly.

## Test plan
- start_addr=0x100; (0,0),(0,5),(2,3); finish → write 0x100 data 0x0004_4002_0005_0001; write 0x101 data 0x0; done; word_count=2.
- (0,20000) → codes 0x8001, 0x0E21 (delta 20001); with finish: word 0x0000_0000_0E21_8001.
- wr_stall held high 10 cycles at the first word → wr_req/addr/data stable; index_stall rises once the packer is blocked; no index lost; order preserved.
- CHECK_EN: (3,4) then (1,2) → err=1 from the cycle after the second index is accepted; (1,2) produces no codes; later valid indexes still encode.
- 8 indexes in one row, col 0..7, then finish → 2 full words plus one word of 0x0000; word_count=3.
- Reset asserted mid-stream after 5 codes → outputs return to reset values; a new start at 0x200 writes its first word to 0x200.

Source files
------------

// File: rtl/pattern_encoder.sv
// pattern_encoder: delta-encodes row-major (row, col) index pairs into 16-bit
// codes, packs four codes per 64-bit word and writes the words to consecutive
// addresses. Optional ordering/range checks: PATTERN_ENCODER_CHECK_EN.
//
// Handshakes: an index transfers on a cycle with index_push && !index_stall.
// A word transfers on a cycle with wr_req && !wr_stall. While wr_req is high
// and wr_stall holds it, wr_addr and wr_data do not change.
module pattern_encoder #(
    parameter int INDEX_WIDTH = 32,
    parameter int ADDR_WIDTH  = 48,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_addr,
    input  logic                   index_push,
    output logic                   index_stall,
    input  logic [INDEX_WIDTH-1:0] row,
    input  logic [INDEX_WIDTH-1:0] col,
    input  logic                   finish,
    output logic                   wr_req,
    input  logic                   wr_stall,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  word_count,
    output logic                   err,
    output logic [2:0]             fsm_state
);

`ifdef PATTERN_ENCODER_CHECK_EN
    // One bit wider than an index so that col+1 and out-of-range deltas stay visible.
    localparam int DW = INDEX_WIDTH + 1;
`else
    // Deltas are taken modulo 2^28 when unchecked.
    localparam int DW = 28;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_FLUSH = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   base_addr, wcount;
    logic [INDEX_WIDTH-1:0]  row_prev, col_prev;
    logic                    col_none;      // col_prev is "-1" (start of stream or of a new row)
    logic [3:0][15:0]        pend;          // codes of the current index, head at [0]
    logic [2:0]              pend_cnt;
    logic [3:0][15:0]        sr;            // packer shift register, code 0 at [0]
    logic [2:0]              sr_cnt;
    logic [3:0][15:0]        sr_nxt;
    logic [2:0]              sr_cnt_nxt;
    logic                    out_valid;
    logic [DATA_WIDTH-1:0]   out_data, load_data;
    logic                    load_out, word_done;
    logic                    out_free, can_push, code_valid, push;
    logic [15:0]             code_in;
    logic                    start_go, index_accept;
    logic                    row_adv, row_ext, col_ext, bad_index;
    logic [DW-1:0]           row_diff, col_diff;
    logic [3:0][15:0]        enc;
    logic [2:0]              enc_cnt;

    assign start_go     = (state == S_IDLE) && start;
    assign out_free     = !out_valid || !wr_stall;
    assign can_push     = (sr_cnt != 3'd4) || out_free;
    assign push         = code_valid && can_push;
    assign index_stall  = (state != S_RUN) || (pend_cnt > 3'd1) || !can_push;
    assign index_accept = index_push && !index_stall;
    assign wr_req       = out_valid;
    assign wr_data      = out_data;
    assign wr_addr      = base_addr + wcount;
    assign word_count   = wcount;
    assign fsm_state    = state;

    // Translate the presented index into its code sequence (row part first).
    always_comb begin
        row_adv  = row > row_prev;
        row_diff = DW'(row) - DW'(row_prev);
        if (row_adv || col_none) col_diff = DW'(col) + DW'(1);
        else                     col_diff = DW'(col) - DW'(col_prev);
        row_ext = row_adv && (row_diff[27:14] != 14'd0);
        col_ext = col_diff[27:14] != 14'd0;
        enc     = {48'd0, 2'b00, col_diff[13:0]};
        enc_cnt = 3'd1;
        if (col_ext) begin
            enc     = {enc[2:0], 2'b10, col_diff[27:14]};
            enc_cnt = enc_cnt + 3'd1;
        end
        if (row_adv) begin
            enc     = {enc[2:0], 2'b01, row_diff[13:0]};
            enc_cnt = enc_cnt + 3'd1;
        end
        if (row_ext) begin
            enc     = {enc[2:0], 2'b10, row_diff[27:14]};
            enc_cnt = enc_cnt + 3'd1;
        end
`ifdef PATTERN_ENCODER_CHECK_EN
        bad_index = (row < row_prev)
                 || ((row == row_prev) && !col_none && (col <= col_prev))
                 || (row_adv && (row_diff[DW-1:28] != '0))
                 || (col_diff[DW-1:28] != '0);
`else
        bad_index = 1'b0;
`endif
    end

    // Code source for the packer: pending index codes, then zeros while flushing.
    always_comb begin
        code_valid = 1'b0;
        code_in    = 16'h0000;
        if (state == S_RUN || state == S_FLUSH) begin
            if (pend_cnt != 3'd0) begin
                code_valid = 1'b1;
                code_in    = pend[0];
            end else if (state == S_FLUSH) begin
                code_valid = 1'b1;
            end
        end
    end

    // Packer next state: retire a held full word, then append the incoming code.
    always_comb begin
        sr_nxt     = sr;
        sr_cnt_nxt = sr_cnt;
        load_out   = 1'b0;
        load_data  = sr;
        word_done  = 1'b0;
        if (sr_cnt == 3'd4 && out_free) begin
            load_out   = 1'b1;
            sr_cnt_nxt = 3'd0;
        end
        if (push) begin
            sr_nxt[sr_cnt_nxt[1:0]] = code_in;
            if (sr_cnt_nxt == 3'd3) begin
                word_done = 1'b1;
                if (out_free) begin
                    load_out   = 1'b1;
                    load_data  = {code_in, sr[2:0]};
                    sr_cnt_nxt = 3'd0;
                end else begin
                    sr_cnt_nxt = 3'd4;
                end
            end else begin
                sr_cnt_nxt = sr_cnt_nxt + 3'd1;
            end
        end
    end

    // FSM next state and done pulse.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (finish) state_nxt = S_FLUSH;
            S_FLUSH: if (push && pend_cnt == 3'd0 && word_done) state_nxt = S_DRAIN;
            S_DRAIN: if (sr_cnt == 3'd0 && out_free) state_nxt = S_DONE;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Stream context: base address and previous index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_addr <= '0;
            row_prev  <= '0;
            col_prev  <= '0;
            col_none  <= 1'b1;
        end else if (start_go) begin
            base_addr <= start_addr;
            row_prev  <= '0;
            col_prev  <= '0;
            col_none  <= 1'b1;
        end else if (index_accept && !bad_index) begin
            if (row_adv) row_prev <= row;
            col_prev <= col;
            col_none <= 1'b0;
        end
    end

    // Pending codes of the current index; a dropped index loads nothing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend     <= '0;
            pend_cnt <= 3'd0;
        end else if (start_go) begin
            pend_cnt <= 3'd0;
        end else if (index_accept) begin
            pend     <= enc;
            pend_cnt <= bad_index ? 3'd0 : enc_cnt;
        end else if (push && pend_cnt != 3'd0) begin
            pend     <= {16'h0000, pend[3:1]};
            pend_cnt <= pend_cnt - 3'd1;
        end
    end

    // Packer shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr     <= '0;
            sr_cnt <= 3'd0;
        end else if (start_go) begin
            sr_cnt <= 3'd0;
        end else begin
            sr     <= sr_nxt;
            sr_cnt <= sr_cnt_nxt;
        end
    end

    // Output word register and accepted-word counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            wcount    <= '0;
        end else begin
            if (load_out) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
            end else if (out_valid && !wr_stall) begin
                out_valid <= 1'b0;
            end
            if (start_go)                  wcount <= '0;
            else if (out_valid && !wr_stall) wcount <= wcount + ADDR_WIDTH'(1);
        end
    end

`ifdef PATTERN_ENCODER_CHECK_EN
    // Sticky error flag, cleared by the next start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                            err <= 1'b0;
        else if (start_go)                   err <= 1'b0;
        else if (index_accept && bad_index)  err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule
